// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states and
// the datapath select/ALU encodings that the existing alu_control also consumes.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001111;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_R_WB      = 4'd3,
    S_EXEC_I    = 4'd4,
    S_I_WB      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12,
    S_ERROR     = 4'd13
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [2:0] ALUIMM_NONE = 3'b000;
  localparam logic [2:0] ALUIMM_ADDI = 3'b001;
  localparam logic [2:0] ALUIMM_SUBI = 3'b010;
  localparam logic [2:0] ALUIMM_ANDI = 3'b011;
  localparam logic [2:0] ALUIMM_ORI  = 3'b100;
  localparam logic [2:0] ALUIMM_SLTI = 3'b101;

  function automatic logic [2:0] alu_imm_encode(input logic [5:0] op);
    case (op)
      OP_ADDI: return ALUIMM_ADDI;
      OP_SUBI: return ALUIMM_SUBI;
      OP_ANDI: return ALUIMM_ANDI;
      OP_ORI:  return ALUIMM_ORI;
      OP_SLTI: return ALUIMM_SLTI;
      default: return ALUIMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on memory; flags expiry on the cycle
// that would exceed the allowed wait, so a same-cycle mem_ready still wins upstream.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = count && (cnt_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences each instruction, handshakes with unified
// memory, traps illegal opcodes and turns memory stalls past the limit into a bus error.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [2:0]          alu_op_imm,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                retire,
  output logic [CNT_W-1:0]    instr_count,
  output logic                trap,
  output logic                bus_error
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_mem_state, wait_count, wait_expired;

  // The timer runs only while a memory state is stalled; any other cycle clears it.
  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                        (state_q == S_MEM_WRITE);
  assign wait_count   = in_mem_state && !mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!wait_count),
    .count   (wait_count),
    .expired (wait_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PCSRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    alu_op        = ALUOP_ADD;
    alu_op_imm    = ALUIMM_NONE;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    retire        = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:                                   state_d = S_EXEC_R;
          OP_LW, OP_SW:                               state_d = S_MEM_ADDR;
          OP_BEQ:                                     state_d = S_BRANCH;
          OP_J:                                       state_d = S_JUMP;
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
          default:                                    state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_IMM;
        alu_op_imm = alu_imm_encode(opcode);
        state_d    = S_I_WB;
      end
      S_I_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (wait_expired) begin
          state_d = S_ERROR;
        end
      end
      S_MEM_WB: begin
        reg_dst    = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (wait_expired) begin
          state_d = S_ERROR;
        end
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP, S_ERROR: state_d = state_q;
      default:         state_d = S_FETCH;
    endcase

    count_d = retire ? count_q + 1'b1 : count_q;
  end

  // Both fault states are absorbing, so the flags stay set until reset.
  assign trap        = (state_q == S_TRAP);
  assign bus_error   = (state_q == S_ERROR);
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle
// against hand-computed control words, plus trap, reset and memory-timeout cases.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic        alu_src_a;
  logic [2:0]  alu_op_imm;
  logic        reg_dst, mem_to_reg, reg_write, retire, trap, bus_error;
  logic [31:0] instr_count;
  logic [19:0] ctlVec;

  int checkCount = 0;
  int errorCount = 0;

  multicycle_control #(.OPCODE_W(6), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .alu_op_imm(alu_op_imm), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .retire(retire), .instr_count(instr_count),
    .trap(trap), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  assign ctlVec = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
                   alu_src_a, alu_src_b, alu_op, alu_op_imm, reg_dst, mem_to_reg,
                   reg_write, retire};

  function automatic logic [19:0] mkCtl(input logic mr, mw, io, irw, pcw, pcwc,
                                        input logic [1:0] pcs, input logic a,
                                        input logic [1:0] b, op, input logic [2:0] imm,
                                        input logic rd, m2r, rw, ret);
    return {mr, mw, io, irw, pcw, pcwc, pcs, a, b, op, imm, rd, m2r, rw, ret};
  endfunction

  localparam logic [19:0] C_FETCH_WAIT = mkCtl(1,0,0,0,0,0,2'b00,0,2'b01,2'b00,3'b000,0,0,0,0);
  localparam logic [19:0] C_FETCH_RDY  = mkCtl(1,0,0,1,1,0,2'b00,0,2'b01,2'b00,3'b000,0,0,0,0);
  localparam logic [19:0] C_DECODE     = mkCtl(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,3'b000,0,0,0,0);
  localparam logic [19:0] C_EXEC_R     = mkCtl(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,3'b000,0,0,0,0);
  localparam logic [19:0] C_R_WB       = mkCtl(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,3'b000,0,0,1,1);
  localparam logic [19:0] C_I_WB       = mkCtl(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,3'b000,1,0,1,1);
  localparam logic [19:0] C_MEM_ADDR   = mkCtl(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,3'b000,0,0,0,0);
  localparam logic [19:0] C_MEM_READ   = mkCtl(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,3'b000,0,0,0,0);
  localparam logic [19:0] C_MEM_WB     = mkCtl(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,3'b000,1,1,1,1);
  localparam logic [19:0] C_WR_WAIT    = mkCtl(0,1,1,0,0,0,2'b00,0,2'b00,2'b00,3'b000,0,0,0,0);
  localparam logic [19:0] C_WR_RDY     = mkCtl(0,1,1,0,0,0,2'b00,0,2'b00,2'b00,3'b000,0,0,0,1);
  localparam logic [19:0] C_BRANCH     = mkCtl(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,3'b000,0,0,0,1);
  localparam logic [19:0] C_JUMP       = mkCtl(0,0,0,0,1,0,2'b10,0,2'b00,2'b00,3'b000,0,0,0,1);
  localparam logic [19:0] C_IDLE       = 20'h0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic z, input logic rdy);
    @(negedge clk);
    rst_n     = 1'b1;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic cycleCheck(input string tag, input logic [5:0] op, input logic z,
                            input logic rdy, input logic [19:0] expCtl);
    applyStimulus(op, z, rdy);
    checkOutput(tag, 32'(ctlVec), 32'(expCtl));
  endtask

  initial begin
    resetDut();
    applyStimulus(6'b000000, 1'b0, 1'b0);
    checkOutput("resetCtl", 32'(ctlVec), 32'(C_FETCH_WAIT));
    checkOutput("resetCount", instr_count, 32'd0);
    checkOutput("resetFlags", 32'({trap, bus_error}), 32'd0);

    // add, zero-wait
    cycleCheck("addFetch", 6'b000000, 0, 1, C_FETCH_RDY);
    cycleCheck("addDecode", 6'b000000, 0, 1, C_DECODE);
    cycleCheck("addExec", 6'b000000, 0, 1, C_EXEC_R);
    cycleCheck("addWb", 6'b000000, 0, 1, C_R_WB);

    // lw with two wait cycles on the data read
    cycleCheck("lwFetch", 6'b100011, 0, 1, C_FETCH_RDY);
    checkOutput("countAfterAdd", instr_count, 32'd1);
    cycleCheck("lwDecode", 6'b100011, 0, 1, C_DECODE);
    cycleCheck("lwAddr", 6'b100011, 0, 1, C_MEM_ADDR);
    cycleCheck("lwWait1", 6'b100011, 0, 0, C_MEM_READ);
    cycleCheck("lwWait2", 6'b100011, 0, 0, C_MEM_READ);
    cycleCheck("lwReady", 6'b100011, 0, 1, C_MEM_READ);
    cycleCheck("lwWb", 6'b100011, 0, 1, C_MEM_WB);

    // slti then addi
    cycleCheck("sltiFetch", 6'b001010, 0, 1, C_FETCH_RDY);
    checkOutput("countAfterLw", instr_count, 32'd2);
    cycleCheck("sltiDecode", 6'b001010, 0, 1, C_DECODE);
    cycleCheck("sltiExec", 6'b001010, 0, 1,
               mkCtl(0,0,0,0,0,0,2'b00,1,2'b10,2'b11,3'b101,0,0,0,0));
    cycleCheck("sltiWb", 6'b001010, 0, 1, C_I_WB);
    cycleCheck("addiFetch", 6'b001000, 0, 1, C_FETCH_RDY);
    cycleCheck("addiDecode", 6'b001000, 0, 1, C_DECODE);
    cycleCheck("addiExec", 6'b001000, 0, 1,
               mkCtl(0,0,0,0,0,0,2'b00,1,2'b10,2'b11,3'b001,0,0,0,0));
    cycleCheck("addiWb", 6'b001000, 0, 1, C_I_WB);

    // sw with one wait cycle
    cycleCheck("swFetch", 6'b101011, 0, 1, C_FETCH_RDY);
    cycleCheck("swDecode", 6'b101011, 0, 1, C_DECODE);
    cycleCheck("swAddr", 6'b101011, 0, 1, C_MEM_ADDR);
    cycleCheck("swWait", 6'b101011, 0, 0, C_WR_WAIT);
    cycleCheck("swReady", 6'b101011, 0, 1, C_WR_RDY);

    // beq taken and not taken, then j
    for (int i = 0; i < 2; i++) begin
      cycleCheck("beqFetch", 6'b000100, 1'(i), 1, C_FETCH_RDY);
      cycleCheck("beqDecode", 6'b000100, 1'(i), 1, C_DECODE);
      cycleCheck("beqExec", 6'b000100, 1'(i), 1, C_BRANCH);
    end
    cycleCheck("jFetch", 6'b000010, 0, 1, C_FETCH_RDY);
    cycleCheck("jDecode", 6'b000010, 0, 1, C_DECODE);
    cycleCheck("jExec", 6'b000010, 0, 1, C_JUMP);

    // illegal opcode
    cycleCheck("trapFetch", 6'b111111, 0, 1, C_FETCH_RDY);
    checkOutput("countAfterJ", instr_count, 32'd8);
    cycleCheck("trapDecode", 6'b111111, 0, 1, C_DECODE);
    for (int i = 0; i < 3; i++) begin
      cycleCheck("trapIdle", 6'b000000, 0, 1, C_IDLE);
      checkOutput("trapFlag", 32'(trap), 32'd1);
      checkOutput("trapCount", instr_count, 32'd8);
    end
    resetDut();
    cycleCheck("trapReset", 6'b000000, 0, 1, C_FETCH_RDY);
    checkOutput("trapCleared", 32'(trap), 32'd0);
    checkOutput("countCleared", instr_count, 32'd0);

    // fetch stalls for the full limit
    resetDut();
    for (int i = 0; i < 16; i++) begin
      cycleCheck("toWait", 6'b000000, 0, 0, C_FETCH_WAIT);
    end
    cycleCheck("toError", 6'b000000, 0, 1, C_IDLE);
    checkOutput("busError", 32'(bus_error), 32'd1);
    cycleCheck("toErrorHold", 6'b000000, 0, 1, C_IDLE);

    // ready arriving on the limit cycle still advances
    resetDut();
    for (int i = 0; i < 15; i++) begin
      cycleCheck("edgeWait", 6'b000000, 0, 0, C_FETCH_WAIT);
    end
    cycleCheck("edgeReady", 6'b000000, 0, 1, C_FETCH_RDY);
    cycleCheck("edgeDecode", 6'b000000, 0, 1, C_DECODE);
    checkOutput("edgeNoError", 32'(bus_error), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
